// File: rtl/sync_div_n_if.sv
// Control and status bundle for the programmable divide-by-N counter.
// The controller drives en/restart/div_m1/div_load; the divider returns count, tick, div_out and pending.
interface sync_div_n_if #(
  parameter int WIDTH = 5
);
  logic             en;
  logic             restart;
  logic [WIDTH-1:0] div_m1;
  logic             div_load;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             div_out;
  logic             pending;

  modport master (
    output en, restart, div_m1, div_load,
    input  count, tick, div_out, pending
  );

  modport slave (
    input  en, restart, div_m1, div_load,
    output count, tick, div_out, pending
  );
endinterface

// File: rtl/sync_div_n.sv
// Programmable divide-by-N down counter producing a terminal-count tick and a near-50% square wave.
// A divisor written through the shadow register is applied only at a period boundary (or on restart).
module sync_div_n #(
  parameter int WIDTH      = 5,
  parameter int DEFAULT_M1 = 31
) (
  input  logic         clk,
  input  logic         reset,
  sync_div_n_if.slave  bus
);

  localparam logic [WIDTH-1:0] DEF_M1 = WIDTH'(DEFAULT_M1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] active_m1;
  logic [WIDTH-1:0] shadow_m1;
  logic             pending_q;
  logic             div_q;

  logic [WIDTH-1:0] sel;
  logic             reload;
  logic             dec;
  logic             count_we;
  logic [WIDTH-1:0] count_nx;
  logic [WIDTH-1:0] active_nx;
  logic [WIDTH:0]   half_nx;
  logic             div_nx;

  always_comb begin
    sel       = pending_q ? shadow_m1 : active_m1;
    // restart always realigns; otherwise the terminal count of an enabled cycle reloads
    reload    = bus.restart | (bus.en & (count_q == '0));
    dec       = bus.en & ~bus.restart & (count_q != '0);
    count_we  = reload | dec;
    count_nx  = count_q;
    active_nx = active_m1;
    if (reload) begin
      count_nx  = sel;
      active_nx = sel;
    end else if (dec) begin
      count_nx  = count_q - 1'b1;
    end
    // high for the upper ceil(N/2) counts of the period that follows
    half_nx = ({1'b0, active_nx} + 1'b1) >> 1;
    div_nx  = ({1'b0, count_nx} >= half_nx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= DEF_M1;
      active_m1 <= DEF_M1;
      shadow_m1 <= DEF_M1;
      pending_q <= 1'b0;
      div_q     <= 1'b1;
    end else begin
      if (count_we) begin
        count_q   <= count_nx;
        active_m1 <= active_nx;
        div_q     <= div_nx;
      end
      // a write in a reload cycle stays pending for the following boundary
      if (bus.div_load) begin
        shadow_m1 <= bus.div_m1;
        pending_q <= 1'b1;
      end else if (reload) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign bus.count   = count_q;
  assign bus.tick    = bus.en & ~bus.restart & (count_q == '0);
  assign bus.div_out = div_q;
  assign bus.pending = pending_q;

endmodule
